// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared constants and enums for the iterative multiplier/divider.
//   WIDTH  - operand/result width
//   ITER   - iteration count for one multiply or divide (one per operand bit)
//   CNT_W  - width of the iteration counter (must hold the value ITER)
//   state_e - control FSM states
//   op_e    - operation selected by a start pulse
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_e;

endpackage

// File: rtl/mult_div_divider.sv
// mult_div_divider: unsigned restoring divider datapath, one quotient bit per step.
//   clock       in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   load_i      in   load dividend/divisor and clear the remainder
//   step_i      in   perform one restoring-division step
//   dividend_i  in   WIDTH  unsigned dividend magnitude
//   divisor_i   in   WIDTH  unsigned divisor magnitude
//   quotient_o  out  WIDTH  quotient after WIDTH steps
// The dividend is shifted out of the top of the quotient register while the
// quotient bits are shifted in at the bottom, so one register serves both.
module mult_div_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  // Partial remainder shifted left with the next dividend bit, and the trial
  // subtraction. Both magnitudes are at most 2^(WIDTH-1), so one extra bit
  // is enough for trial[WIDTH] to be a valid borrow/sign bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dsr_d = divisor_i;
    end else if (step_i) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/mult_div.sv
// mult_div: iterative signed multiplier (radix-2 Booth) / divider (restoring,
// on magnitudes). A start pulse latches the operands; the result appears with
// a one-cycle ready pulse 33 cycles later. A new start aborts any operation.
//   clock           in   clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   data_operandA   in   WIDTH  signed multiplicand / dividend (start cycle only)
//   data_operandB   in   WIDTH  signed multiplier / divisor (start cycle only)
//   ctrl_MULT       in   start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   start divide
//   data_result     out  WIDTH  signed result, held until the next completion
//   data_exception  out  multiply overflow, divide-by-zero or MIN/-1
//   data_resultRDY  out  one-cycle pulse: result valid
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = mult_div_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  // One iteration per operand bit; only WIDTH == ITER is exercised.
  localparam int              LCL_CNT_W = $clog2(WIDTH + 1);
  localparam logic [LCL_CNT_W-1:0] LAST_CNT = LCL_CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                 state_q, state_d;
  logic [LCL_CNT_W-1:0]   cnt_q, cnt_d;
  // Booth register {A, Q, q_-1}; {A, Q} is the 2*WIDTH-bit product at the end.
  logic [2*WIDTH:0]       booth_q, booth_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic                   neg_q, neg_d;
  logic                   div_zero_q, div_zero_d;
  logic                   div_ovf_q, div_ovf_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   exc_q, exc_d;

  logic                   start;
  op_e                    start_op;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic                   div_load, div_step;
  logic [WIDTH-1:0]       quot_mag;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign start_op = ctrl_MULT ? OP_MUL : OP_DIV;
  assign mag_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign div_load = start && (start_op == OP_DIV);

  // Booth step. The accumulator is sign-extended by one bit so A +/- M cannot
  // overflow even for the most negative multiplicand; the arithmetic right
  // shift then drops that extra bit back out of the register.
  logic [WIDTH:0]         booth_acc, booth_mcand, booth_sum;
  logic [2*WIDTH:0]       booth_next;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH:0]         prod_hi;

  assign booth_acc   = {booth_q[2*WIDTH], booth_q[2*WIDTH:WIDTH+1]};
  assign booth_mcand = {mcand_q[WIDTH-1], mcand_q};
  assign product     = booth_q[2*WIDTH:1];
  assign prod_hi     = product[2*WIDTH-1:WIDTH-1];

  always_comb begin
    booth_sum = booth_acc;
    case (booth_q[1:0])
      2'b01:   booth_sum = booth_acc + booth_mcand;
      2'b10:   booth_sum = booth_acc - booth_mcand;
      default: booth_sum = booth_acc;
    endcase
  end

  assign booth_next = {booth_sum, booth_q[WIDTH:1]};

  mult_div_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quotient_o (quot_mag)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    booth_d    = booth_q;
    mcand_d    = mcand_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    result_d   = result_q;
    exc_d      = exc_q;
    div_step   = 1'b0;

    if (start) begin
      // A start is honoured in every state and silently abandons any work.
      state_d    = (start_op == OP_MUL) ? MUL : DIV;
      cnt_d      = '0;
      booth_d    = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      mcand_d    = data_operandA;
      neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero_d = (data_operandB == '0);
      div_ovf_d  = (data_operandA == MIN_NEG) && (data_operandB == '1);
    end else begin
      case (state_q)
        MUL: begin
          if (cnt_q == LAST_CNT) begin
            state_d  = DONE;
            result_d = product[WIDTH-1:0];
            // Representable iff the top WIDTH+1 product bits are all equal.
            exc_d    = !((&prod_hi) || !(|prod_hi));
          end else begin
            booth_d = booth_next;
            cnt_d   = cnt_q + LCL_CNT_W'(1);
          end
        end
        DIV: begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            if (div_zero_q) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else if (div_ovf_q) begin
              result_d = MIN_NEG;
              exc_d    = 1'b1;
            end else begin
              result_d = neg_q ? -quot_mag : quot_mag;
              exc_d    = 1'b0;
            end
          end else begin
            div_step = 1'b1;
            cnt_d    = cnt_q + LCL_CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      booth_q    <= '0;
      mcand_q    <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      booth_q    <= booth_d;
      mcand_q    <= mcand_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
    end
  end

  // DONE lasts exactly one cycle, so the ready pulse is a decode of the state.
  assign data_resultRDY = (state_q == DONE);
  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: self-checking bench for mult_div against a plain-arithmetic model.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] prev_res = '0;
  logic        prev_exc = 1'b0;

  mult_div #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: full-precision signed arithmetic.
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa;
    longint sb;
    longint p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mul) begin
      p = sa * sb;
      r = p[31:0];
      e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end else if (sb == 0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  task automatic start_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = !is_mul;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] er;
    logic        ee;
    int          lat;
    model(is_mul, a, b, er, ee);
    start_op(is_mul, a, b);
    n_checks++;
    if (data_result !== prev_res || data_exception !== prev_exc) begin
      n_fail++;
      $display("FAIL %s hold: result=%h exc=%b, required %h exc=%b", name,
               data_result, data_exception, prev_res, prev_exc);
    end
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    n_checks++;
    if (data_resultRDY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: no ready within %0d cycles", name, lat);
    end else begin
      if (lat !== 33) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, required 33", name, lat);
      end
      n_checks++;
      if (data_result !== er || data_exception !== ee) begin
        n_fail++;
        $display("FAIL %s result: got %0d exc=%b, required %0d exc=%b", name,
                 $signed(data_result), data_exception, $signed(er), ee);
      end
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== 1'b0) begin
        n_fail++;
        $display("FAIL %s pulse width: ready still %b, required 0", name, data_resultRDY);
      end
    end
    prev_res = er;
    prev_exc = ee;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state: result=%h exc=%b rdy=%b, required 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    int pulses;
    pulses = 0;
    repeat (10) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL idle: %0d ready pulses, required 0", pulses);
    end
  endtask

  task automatic test_directed();
    run_op(1'b1, 32'd7, -32'sd3, "mul 7*-3");
    run_op(1'b1, 32'd65536, 32'd65536, "mul 65536*65536");
    run_op(1'b1, 32'h8000_0000, 32'd1, "mul min*1");
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "mul min*min");
    run_op(1'b0, 32'd100, 32'd7, "div 100/7");
    run_op(1'b0, -32'sd7, 32'd2, "div -7/2");
    run_op(1'b0, 32'd7, -32'sd7, "div 7/-7");
    run_op(1'b0, 32'd5, 32'd0, "div 5/0");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    run_op(1'b0, 32'h8000_0000, 32'd1, "div min/1");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) begin
        a = 32'($urandom_range(0, 60000)) - 32'd30000;
        b = 32'($urandom_range(0, 60000)) - 32'd30000;
      end
      run_op(1'b1, a, b, "rand mul");
    end
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) b = 32'($urandom_range(0, 20)) - 32'd10;
      if (i % 4 == 2) b = b >> $urandom_range(0, 31);
      run_op(1'b0, a, b, "rand div");
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(1'b1, 32'd3, 32'd5);
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    n_checks++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd15 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b first: rdy=%b result=%0d exc=%b, required 1/15/0",
               data_resultRDY, $signed(data_result), data_exception);
    end
    // Start the next operation in the same cycle as the ready pulse.
    data_operandA = -32'sd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    n_checks++;
    if (lat !== 33 || data_result !== -32'sd14 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b second: latency=%0d result=%0d exc=%b, required 33/-14/0",
               lat, $signed(data_result), data_exception);
    end
    prev_res = -32'sd14;
    prev_exc = 1'b0;
  endtask

  task automatic test_restart();
    int pulses;
    int first;
    logic [31:0] got_res;
    logic        got_exc;
    start_op(1'b1, 32'd123456, 32'd789);
    repeat (5) @(negedge clock);
    start_op(1'b0, 32'd100, 32'd10);
    pulses  = 0;
    first   = -1;
    got_res = '0;
    got_exc = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first   = c;
          got_res = data_result;
          got_exc = data_exception;
        end
      end
    end
    n_checks++;
    if (pulses !== 1 || first !== 33) begin
      n_fail++;
      $display("FAIL restart pulses: %0d pulses first at %0d, required 1 at 33", pulses, first);
    end
    n_checks++;
    if (got_res !== 32'd10 || got_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL restart result: got %0d exc=%b, required 10 exc=0",
               $signed(got_res), got_exc);
    end
    prev_res = 32'd10;
    prev_exc = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    run_op(1'b0, 32'd5, 32'd0, "div 5/0 before reset");
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: result=%h exc=%b rdy=%b, required 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset discard: %0d ready pulses, required 0", pulses);
    end
    prev_res = 32'd0;
    prev_exc = 1'b0;
    run_op(1'b1, 32'd6, 32'd7, "mul 6*7 after reset");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_directed();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Iterative signed 32-bit multiplier/divider used as the long-latency execution unit beside the ALU. It accepts a one-cycle start pulse for multiply or divide, latches both operands, and iterates over multiple cycles. It then presents a 32-bit result and an exception flag, marked by a one-cycle `data_resultRDY` pulse.

## Interface
- `WIDTH`, default 32, operand/result width. Only 32 is verified.

- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `data_operandA`  in  32  signed dividend / multiplicand; sampled only in the start cycle
- `data_operandB`  in  32  signed divisor / multiplier; sampled only in the start cycle
- `ctrl_MULT`  in  1  start multiply; one-cycle pulse
- `ctrl_DIV`  in  1  start divide; one-cycle pulse
- `data_result`  out  32  signed result
- `data_exception`  out  1  overflow or divide-by-zero
- `data_resultRDY`  out  1  one-cycle pulse: result valid

## Operation
- **States**
  - IDLE, MUL, DIV, DONE.
  - A rising edge with `ctrl_MULT` or `ctrl_DIV` high is a start from any state.
  - A start latches both operands, clears the counter and enters MUL or DIV.
  - If both controls are high, multiply wins.
- **Restart**: a start during MUL/DIV/DONE aborts the current operation silently. No ready pulse is produced for the aborted operation.
- **Multiply**
  - Radix-2 Booth, 32 iterations, on a 65-bit {product, Q-1} register.
  - `data_result` is product[31:0].
  - `data_exception` is 1 iff the full 64-bit signed product is not representable in 32 bits, i.e. product[63:31] is not all equal.
- **Divide**
  - Operate on magnitudes with non-restoring or restoring division, 32 iterations.
  - Quotient sign is signA XOR signB. Truncate toward zero; the remainder is discarded.
  - Divisor 0: `data_result`=0, `data_exception`=1.
  - −2^31 / −1: `data_result`=0x80000000, `data_exception`=1.
  - All other divides: `data_exception`=0.
- **Output holding**: `data_result` and `data_exception` update only when entering DONE. They hold until the next DONE; a start does not clear them.
- **Reset**
  - All outputs go to 0 and the state goes to IDLE, immediately (asynchronously).
  - Reset mid-operation discards the operation.
  - Starts are accepted on the first edge after release.

## Timing
- Start sampled at edge E0.
- Iterations run on edges E1..E32.
- `data_resultRDY`, `data_result` and `data_exception` become valid after edge E33.
- `data_resultRDY` is high for exactly one cycle, then the block returns to IDLE.
- Latency start→ready: 33 cycles. Worst case must stay under 100 cycles.
- Divide-by-zero takes the same 33-cycle latency; no early completion.
- Operands may change freely after E0.
- `ctrl_*` low in IDLE/DONE keeps the block idle; `data_resultRDY` stays 0.

## Structure
- Shared package `mult_div_pkg`:
  - WIDTH and ITER (32) constants.
  - State enum {IDLE, MUL, DIV, DONE}.
  - Opcode enum {OP_MUL, OP_DIV}.
- One natural sub-module, `mult_div_divider`: the magnitude divider datapath (remainder/quotient registers, step adder).
- The Booth multiplier, sign handling, FSM and output registers live in the top.
- Expected size: about 200–300 lines of RTL.

## Test plan
- 7 × −3 → result −21, exception 0; ready exactly 33 cycles after start, for one cycle.
- 65536 × 65536 → result 0, exception 1. Then −2147483648 × 1 → result −2147483648, exception 0.
- 100 / 7 → 14, exception 0. −7 / 2 → −3, exception 0. 7 / −7 → −1, exception 0.
- 5 / 0 → result 0, exception 1. −2147483648 / −1 → 0x80000000, exception 1.
- Start 123456 × 789 and change operands the next cycle. Then after 5 cycles start 100 / 10 → only one ready pulse, result 10, exception 0.
- Assert `reset_n` low mid-divide → outputs 0 immediately, no ready. After release, 6 × 7 → 42, exception 0.
